seq_mult8_shift_add: RTL and testbench

//   Sequential unsigned 8x8 -> 16-bit multiplier that consumes the team's 8-bit carry-lookahead adder.

---
 rtl/seq_mult8_shift_add_pkg.sv | 13 +
 rtl/seq_mult8_shift_add_adder.sv | 41 ++++
 rtl/seq_mult8_shift_add.sv | 85 ++++++++
 tb/tb_seq_mult8_shift_add.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seq_mult8_shift_add_pkg.sv
// Shared definitions for the team's multi-cycle arithmetic blocks.
package seq_mult8_shift_add_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult8_shift_add_adder.sv
// 8-bit carry-lookahead adder/subtractor: S = A + (E ^ {8{m}}) + m.
// c7 is the carry out of bit 7, c6 the carry out of bit 6.
module adder (
  input  logic [7:0] A,
  input  logic [7:0] E,
  input  logic       m,
  output logic [7:0] S,
  output logic       c7,
  output logic       c6
);

  logic [7:0] e_x;
  logic [7:0] gen;
  logic [7:0] prop;
  logic [7:0] carry;

  assign e_x  = E ^ {8{m}};
  assign gen  = A & e_x;
  assign prop = A ^ e_x;

  // Each carry is expanded as a flat generate/propagate term, not rippled.
  always_comb begin
    carry = '0;
    for (int i = 0; i < 8; i++) begin
      logic pp;
      logic cc;
      cc = gen[i];
      pp = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        cc = cc | (pp & gen[j]);
        pp = pp & prop[j];
      end
      carry[i] = cc | (pp & m);
    end
  end

  assign S  = prop ^ {carry[6:0], m};
  assign c7 = carry[7];
  assign c6 = carry[6];

endmodule

// File: rtl/seq_mult8_shift_add.sv
// Sequential unsigned 8x8 -> 16 shift-add multiplier with valid/ready on both sides.
// One conditional add and one right shift per RUN cycle, 8 cycles per operand pair.
module seq_mult8_shift_add
  import seq_mult8_shift_add_pkg::*;
#(
  parameter int WIDTH = seq_mult8_shift_add_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  if (WIDTH != 8) begin : g_bad_width
    $error("seq_mult8_shift_add supports WIDTH=8 only");
  end

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] add_e;
  logic [WIDTH-1:0] add_s;
  logic             add_c7;
  logic             add_c6_unused;

  assign add_e = acc_lo_q[0] ? mcand_q : '0;

  adder u_adder (
    .A  (acc_hi_q),
    .E  (add_e),
    .m  (1'b0),
    .S  (add_s),
    .c7 (add_c7),
    .c6 (add_c6_unused)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= a;
            acc_lo_q <= b;
            acc_hi_q <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          // The 9-bit sum (carry included) shifts down into the accumulator.
          {acc_hi_q, acc_lo_q} <= {add_c7, add_s, acc_lo_q[WIDTH-1:1]};
          cnt_q                <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= DONE;
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // in_ready is gated by rst so upstream never sees acceptance during reset.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign product   = {acc_hi_q, acc_lo_q};

endmodule

// File: tb/tb_seq_mult8_shift_add.sv
// Directed self-checking bench for seq_mult8_shift_add.
module tb_seq_mult8_shift_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  seq_mult8_shift_add dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Accepts one operand pair, waits (bounded) for out_valid and checks latency and result.
  // glitch_at >= 0 pulses in_valid with a=b=1 during that RUN cycle.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [15:0] exp, input string tag, input int glitch_at);
    int cyc;
    int busy_cnt;
    check({tag, " in_ready before"}, 32'(in_ready), 1);
    a        = ta;
    b        = tb_v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc      = 0;
    busy_cnt = 32'(busy);
    while (!out_valid && cyc < 20) begin
      if (cyc == glitch_at) begin
        in_valid = 1'b1;
        a        = 8'd1;
        b        = 8'd1;
        check({tag, " in_ready during RUN"}, 32'(in_ready), 0);
      end else begin
        in_valid = 1'b0;
        a        = ta;
        b        = tb_v;
      end
      @(posedge clk); #1;
      cyc++;
      if (!out_valid) busy_cnt += 32'(busy);
    end
    in_valid = 1'b0;
    a        = ta;
    b        = tb_v;
    check({tag, " latency"}, 32'(cyc), 8);
    check({tag, " busy cycles"}, 32'(busy_cnt), 8);
    check({tag, " out_valid"}, 32'(out_valid), 1);
    check({tag, " busy in DONE"}, 32'(busy), 0);
    check({tag, " product"}, 32'(product), 32'(exp));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, " out_valid after accept"}, 32'(out_valid), 0);
    check({tag, " in_ready after accept"}, 32'(in_ready), 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'd0;
    b         = 8'd0;

    // Reset held for two edges; in_ready must stay low while rst is high even in IDLE.
    @(posedge clk); #1;
    check("rst in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("reset in_ready", 32'(in_ready), 1);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset product", 32'(product), 0);

    // 13 * 11 with out_ready held high: DONE lasts one cycle.
    out_ready = 1'b1;
    run_op(8'd13, 8'd11, 16'h008F, "13x11", -1);
    @(posedge clk); #1;
    expect_idle("13x11");

    // Carry out of the adder used on every step.
    run_op(8'hFF, 8'hFF, 16'hFE01, "FFxFF", -1);
    @(posedge clk); #1;
    expect_idle("FFxFF");

    // Zero multiplicand still takes the full 8 cycles.
    run_op(8'h00, 8'h5A, 16'h0000, "0x5A", -1);
    @(posedge clk); #1;
    expect_idle("0x5A");

    // Back-pressure: result holds stable for 5 cycles in DONE.
    out_ready = 1'b0;
    run_op(8'd200, 8'd3, 16'h0258, "200x3", -1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("200x3 hold out_valid", 32'(out_valid), 1);
      check("200x3 hold product", 32'(product), 32'h0258);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    expect_idle("200x3");

    // in_valid pulse during RUN must not disturb the in-flight operation.
    run_op(8'd7, 8'd9, 16'h003F, "7x9 glitch", 2);
    @(posedge clk); #1;
    expect_idle("7x9 glitch");
    @(posedge clk); #1;
    check("7x9 no restart", 32'(busy), 0);

    // Reset mid-RUN discards the in-flight product.
    a        = 8'd13;
    b        = 8'd11;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort busy before rst", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort in_ready during rst", 32'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort busy", 32'(busy), 0);
    check("abort out_valid", 32'(out_valid), 0);
    check("abort product", 32'(product), 0);
    run_op(8'd5, 8'd6, 16'h001E, "5x6 after abort", -1);
    @(posedge clk); #1;
    expect_idle("5x6 after abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
